// File: rtl/mlp_if_loader_if.sv
// Handshake bundle between the host byte stream / mlp_main and the RAM_IF loader.
// The loader takes the slave view; the upstream/test side takes the master view.
interface mlp_if_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              IN_VALID_I;
    logic              IN_READY_O;
    logic [DATA_W-1:0] IN_DATA_I;
    logic              IN_LAST_I;
    logic              RAM_IF_WE_O;
    logic [ADDR_W-1:0] RAM_IF_ADDR_O;
    logic [DATA_W-1:0] RAM_IF_WDATA_O;
    logic              EN_O;
    logic              MLP_DONE_I;
    logic              BUSY_O;
    logic              ERR_O;
    logic [7:0]        FRAME_CNT_O;

    modport slave (
        input  IN_VALID_I, IN_DATA_I, IN_LAST_I, MLP_DONE_I,
        output IN_READY_O, RAM_IF_WE_O, RAM_IF_ADDR_O, RAM_IF_WDATA_O,
               EN_O, BUSY_O, ERR_O, FRAME_CNT_O
    );

    modport master (
        output IN_VALID_I, IN_DATA_I, IN_LAST_I, MLP_DONE_I,
        input  IN_READY_O, RAM_IF_WE_O, RAM_IF_ADDR_O, RAM_IF_WDATA_O,
               EN_O, BUSY_O, ERR_O, FRAME_CNT_O
    );
endinterface

// File: rtl/mlp_if_loader.sv
// Loads one image frame into RAM_IF over a valid/ready stream, then starts the
// MLP and blocks further input until the MLP reports done.
module mlp_if_loader #(
    parameter int NUM_PIX = 784,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8
) (
    input  logic            CK,
    input  logic            RB,
    mlp_if_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_START = 2'b10,
        S_WAIT  = 2'b11
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              en_q, en_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              ready;
    logic              xfer;
    logic [ADDR_W-1:0] cur_idx;

    // Ready is forced low while reset is held so every output reads 0 in reset.
    assign ready   = RB && ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign xfer    = bus.IN_VALID_I & ready;
    assign cur_idx = (state_q == S_IDLE) ? '0 : idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        en_d    = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = cur_idx;
                    wdata_d = bus.IN_DATA_I;
                    if (state_q == S_IDLE) err_d = 1'b0;
                    if (cur_idx == LAST_IDX) begin
                        idx_d = '0;
                        if (bus.IN_LAST_I) begin
                            state_d = S_START;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (bus.IN_LAST_I) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = cur_idx + ADDR_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_START: begin
                en_d    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.MLP_DONE_I) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            en_q    <= en_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.IN_READY_O     = ready;
    assign bus.RAM_IF_WE_O    = we_q;
    assign bus.RAM_IF_ADDR_O  = addr_q;
    assign bus.RAM_IF_WDATA_O = wdata_q;
    assign bus.EN_O           = en_q;
    assign bus.BUSY_O         = (state_q == S_START) || (state_q == S_WAIT);
    assign bus.ERR_O          = err_q;
    assign bus.FRAME_CNT_O    = cnt_q;

endmodule
